// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor
//   Watches a left-rotating one-hot ring counter. It locks after LOCK_CNT
//   consecutive correct advances, then reports the binary phase of the
//   active bit, counts revolutions (wraps into bit 0) and flags any
//   illegal value (err_onehot) or wrong advance (err_seq). err_sticky
//   records that any error has occurred since the last clr_err or rst.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   ring_in    [N-1:0] ring counter output
//   ring_load  ring preload strobe: resynchronise without raising an error
//   clr_err    clears err_sticky (a new error on the same edge wins)
//   phase      [PHASE_W-1:0] index of the active bit, valid while locked
//   locked     high while in LOCKED
//   rev_count  [REV_W-1:0] revolutions completed while locked
//   err_onehot one-cycle pulse, non-one-hot value while locked
//   err_seq    one-cycle pulse, one-hot but wrong advance while locked
//   err_sticky sticky error flag
module ring_phase_monitor #(
  parameter int N        = 4,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 8,
  localparam int PHASE_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       ring_in,
  input  logic               ring_load,
  input  logic               clr_err,
  output logic [PHASE_W-1:0] phase,
  output logic               locked,
  output logic [REV_W-1:0]   rev_count,
  output logic               err_onehot,
  output logic               err_seq,
  output logic               err_sticky
);

  // Wide enough to hold the value LOCK_CNT itself.
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [N-1:0]        last_reg, last_next;
  logic [GOOD_W-1:0]   good_reg, good_next;
  logic [PHASE_W-1:0]  phase_reg, phase_next;
  logic                locked_reg, locked_next;
  logic [REV_W-1:0]    rev_reg, rev_next;
  logic                eoh_reg, eoh_next;
  logic                eseq_reg, eseq_next;
  logic                sticky_reg, sticky_next;

  logic                oh;
  logic [N-1:0]        nxt;
  logic [PHASE_W-1:0]  enc;
  logic [GOOD_W-1:0]   good_inc;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign oh  = (ring_in != '0) && ((ring_in & (ring_in - N'(1))) == '0);
  assign nxt = {last_reg[N-2:0], last_reg[N-1]};
  assign good_inc = good_reg + GOOD_W'(1);

  // OR-based encoder: phase bit b is the OR of every ring bit whose index has
  // bit b set. Only correct for one-hot inputs, which is the only case used.
  logic [PHASE_W-1:0][N-1:0] sel;
  generate
    for (genvar gi = 0; gi < PHASE_W; gi++) begin : g_enc_bit
      for (genvar gj = 0; gj < N; gj++) begin : g_enc_src
        if (((gj >> gi) % 2) == 1) begin : g_use
          assign sel[gi][gj] = ring_in[gj];
        end else begin : g_zero
          assign sel[gi][gj] = 1'b0;
        end
      end
      assign enc[gi] = |sel[gi];
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    last_next   = last_reg;
    good_next   = good_reg;
    phase_next  = phase_reg;
    locked_next = locked_reg;
    rev_next    = rev_reg;
    eoh_next    = 1'b0;
    eseq_next   = 1'b0;
    sticky_next = clr_err ? 1'b0 : sticky_reg;

    if (ring_load) begin
      // Resynchronise: everything observable except lock and pulses is kept.
      state_next  = SEARCH;
      good_next   = '0;
      locked_next = 1'b0;
      sticky_next = sticky_reg;
    end else begin
      case (state_reg)
        SEARCH: begin
          if (oh) begin
            last_next  = ring_in;
            good_next  = '0;
            state_next = CHECK;
          end
        end
        CHECK: begin
          if (ring_in == nxt) begin
            last_next = ring_in;
            good_next = good_inc;
            if (good_inc == GOOD_W'(LOCK_CNT)) begin
              state_next  = LOCKED;
              locked_next = 1'b1;
              phase_next  = enc;
            end
          end else if (oh) begin
            last_next = ring_in;
            good_next = '0;
          end else begin
            state_next = SEARCH;
            good_next  = '0;
          end
        end
        LOCKED: begin
          if (ring_in == nxt) begin
            last_next  = ring_in;
            phase_next = enc;
            // Landing on bit 0 completes a revolution.
            if (ring_in[0]) begin
              rev_next = rev_reg + REV_W'(1);
            end
          end else begin
            state_next  = SEARCH;
            locked_next = 1'b0;
            good_next   = '0;
            sticky_next = 1'b1;
            if (!oh) begin
              eoh_next = 1'b1;
            end else begin
              eseq_next = 1'b1;
            end
          end
        end
        default: begin
          state_next  = SEARCH;
          good_next   = '0;
          locked_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= SEARCH;
      last_reg   <= '0;
      good_reg   <= '0;
      phase_reg  <= '0;
      locked_reg <= 1'b0;
      rev_reg    <= '0;
      eoh_reg    <= 1'b0;
      eseq_reg   <= 1'b0;
      sticky_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      last_reg   <= last_next;
      good_reg   <= good_next;
      phase_reg  <= phase_next;
      locked_reg <= locked_next;
      rev_reg    <= rev_next;
      eoh_reg    <= eoh_next;
      eseq_reg   <= eseq_next;
      sticky_reg <= sticky_next;
    end
  end

  assign phase      = phase_reg;
  assign locked     = locked_reg;
  assign rev_count  = rev_reg;
  assign err_onehot = eoh_reg;
  assign err_seq    = eseq_reg;
  assign err_sticky = sticky_reg;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Bench for ring_phase_monitor with N=4, LOCK_CNT=2, REV_W=2 (small REV_W so
// the revolution counter wrap is reachable). Each step pushes its expected
// output word to a scoreboard queue; each scenario task then pops and
// compares against the words captured one cycle after each drive.
module tb_ring_phase_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] ring_in;
  logic       ring_load;
  logic       clr_err;
  logic [1:0] phase;
  logic       locked;
  logic [1:0] rev_count;
  logic       err_onehot;
  logic       err_seq;
  logic       err_sticky;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic       lk;
    logic [1:0] ph;
    logic [1:0] rv;
    logic       eoh;
    logic       eseq;
    logic       st;
  } exp_t;

  exp_t  sb[$];
  exp_t  oq[$];
  string nq[$];

  ring_phase_monitor #(.N(4), .LOCK_CNT(2), .REV_W(2)) dut (
    .clk(clk), .rst(rst), .ring_in(ring_in), .ring_load(ring_load),
    .clr_err(clr_err), .phase(phase), .locked(locked), .rev_count(rev_count),
    .err_onehot(err_onehot), .err_seq(err_seq), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input logic lk, input int ph, input int rv,
                              input logic eoh, input logic eseq, input logic st);
    exp_t e;
    e.lk = lk; e.ph = 2'(ph); e.rv = 2'(rv % 4);
    e.eoh = eoh; e.eseq = eseq; e.st = st;
    return e;
  endfunction

  // Drive one cycle of stimulus, record its expectation and the DUT response.
  task automatic drive(input logic rs, input logic ld, input logic cl,
                       input logic [3:0] r, input exp_t e, input string nm);
    rst = rs; ring_load = ld; clr_err = cl; ring_in = r;
    sb.push_back(e);
    nq.push_back(nm);
    @(posedge clk);
    #1;
    oq.push_back({locked, phase, rev_count, err_onehot, err_seq, err_sticky});
    rst = 1'b0; ring_load = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, o; string n;
    drive(1, 0, 0, 4'b0000, ex(0,0,0,0,0,0), "reset");
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = oq.pop_front(); n = nq.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s got %b want %b (lk,ph,rev,eoh,eseq,st)", n, o, e);
      else begin passes++; $display("ok   %s %b", n, o); end
    end
  endtask

  task automatic test_lock_wrap();
    exp_t e, o; string n;
    drive(0, 0, 0, 4'b0001, ex(0,0,0,0,0,0), "lock_0001");
    drive(0, 0, 0, 4'b0010, ex(0,0,0,0,0,0), "lock_0010");
    drive(0, 0, 0, 4'b0100, ex(1,2,0,0,0,0), "lock_0100");
    drive(0, 0, 0, 4'b1000, ex(1,3,0,0,0,0), "lock_1000");
    drive(0, 0, 0, 4'b0001, ex(1,0,1,0,0,0), "wrap_0001");
    drive(0, 0, 0, 4'b0010, ex(1,1,1,0,0,0), "wrap_0010");
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = oq.pop_front(); n = nq.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s got %b want %b (lk,ph,rev,eoh,eseq,st)", n, o, e);
      else begin passes++; $display("ok   %s %b", n, o); end
    end
  endtask

  task automatic test_skip();
    exp_t e, o; string n;
    drive(0, 0, 0, 4'b1000, ex(0,1,1,0,1,1), "skip_err");
    drive(0, 0, 0, 4'b0001, ex(0,1,1,0,0,1), "skip_pulse_end");
    drive(0, 0, 0, 4'b0010, ex(0,1,1,0,0,1), "skip_check");
    drive(0, 0, 0, 4'b0100, ex(1,2,1,0,0,1), "skip_relock");
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = oq.pop_front(); n = nq.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s got %b want %b (lk,ph,rev,eoh,eseq,st)", n, o, e);
      else begin passes++; $display("ok   %s %b", n, o); end
    end
  endtask

  task automatic test_onehot();
    exp_t e, o; string n;
    drive(0, 0, 0, 4'b0110, ex(0,2,1,1,0,1), "onehot_err");
    for (int i = 0; i < 3; i++)
      drive(0, 0, 0, 4'b0000, ex(0,2,1,0,0,1), "onehot_zero_search");
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = oq.pop_front(); n = nq.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s got %b want %b (lk,ph,rev,eoh,eseq,st)", n, o, e);
      else begin passes++; $display("ok   %s %b", n, o); end
    end
  endtask

  task automatic test_stall();
    exp_t e, o; string n;
    drive(0, 0, 0, 4'b0001, ex(0,2,1,0,0,1), "stall_acq0");
    drive(0, 0, 0, 4'b0010, ex(0,2,1,0,0,1), "stall_acq1");
    drive(0, 0, 0, 4'b0100, ex(1,2,1,0,0,1), "stall_lock");
    drive(0, 0, 0, 4'b0100, ex(0,2,1,0,1,1), "stall_err");
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = oq.pop_front(); n = nq.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s got %b want %b (lk,ph,rev,eoh,eseq,st)", n, o, e);
      else begin passes++; $display("ok   %s %b", n, o); end
    end
  endtask

  task automatic test_ring_load();
    exp_t e, o; string n;
    drive(0, 0, 0, 4'b0001, ex(0,2,1,0,0,1), "load_acq0");
    drive(0, 0, 0, 4'b0010, ex(0,2,1,0,0,1), "load_acq1");
    drive(0, 0, 0, 4'b0100, ex(1,2,1,0,0,1), "load_lock");
    drive(0, 0, 0, 4'b1000, ex(1,3,1,0,0,1), "load_ph3");
    drive(0, 0, 0, 4'b0001, ex(1,0,2,0,0,1), "load_rev2");
    drive(0, 1, 0, 4'b0001, ex(0,0,2,0,0,1), "load_resync");
    drive(0, 0, 0, 4'b0001, ex(0,0,2,0,0,1), "load_search");
    drive(0, 0, 0, 4'b0010, ex(0,0,2,0,0,1), "load_adv1");
    drive(0, 0, 0, 4'b0100, ex(1,2,2,0,0,1), "load_relock");
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = oq.pop_front(); n = nq.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s got %b want %b (lk,ph,rev,eoh,eseq,st)", n, o, e);
      else begin passes++; $display("ok   %s %b", n, o); end
    end
  endtask

  task automatic test_clear_wrap();
    exp_t e, o; string n;
    logic [3:0] seq [4];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    drive(1, 0, 0, 4'b0000, ex(0,0,0,0,0,0), "rst_clears_sticky");
    drive(0, 0, 0, 4'b0001, ex(0,0,0,0,0,0), "cw_acq0");
    drive(0, 0, 0, 4'b0010, ex(0,0,0,0,0,0), "cw_acq1");
    drive(0, 0, 0, 4'b0100, ex(1,2,0,0,0,0), "cw_lock");
    drive(0, 0, 0, 4'b1000, ex(1,3,0,0,0,0), "cw_ph3");
    for (int k = 1; k <= 5; k++)
      for (int p = 0; p < 4; p++)
        drive(0, 0, 0, seq[p], ex(1,p,k,0,0,0), $sformatf("rev%0d_ph%0d", k, p));
    drive(0, 0, 0, 4'b1000, ex(0,3,1,0,1,1), "cw_stall_err");
    drive(0, 0, 1, 4'b0000, ex(0,3,1,0,0,0), "clr_alone");
    drive(0, 0, 0, 4'b0001, ex(0,3,1,0,0,0), "cw_reacq0");
    drive(0, 0, 0, 4'b0010, ex(0,3,1,0,0,0), "cw_reacq1");
    drive(0, 0, 0, 4'b0100, ex(1,2,1,0,0,0), "cw_relock");
    drive(0, 0, 1, 4'b0100, ex(0,2,1,0,1,1), "clr_with_err_set_wins");
    drive(0, 0, 1, 4'b0000, ex(0,2,1,0,0,0), "clr_alone_again");
    while (sb.size() > 0) begin
      e = sb.pop_front(); o = oq.pop_front(); n = nq.pop_front();
      checks++;
      if (o !== e) $display("FAIL %s got %b want %b (lk,ph,rev,eoh,eseq,st)", n, o, e);
      else begin passes++; $display("ok   %s %b", n, o); end
    end
  endtask

  initial begin
    rst = 1'b1; ring_load = 1'b0; clr_err = 1'b0; ring_in = 4'b0000;
    test_reset();
    test_lock_wrap();
    test_skip();
    test_onehot();
    test_stall();
    test_ring_load();
    test_clear_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
Downstream consumer of the one-hot ring counter. It samples the ring output every clock and checks that it is a legal one-hot value advancing one position per cycle. It encodes the active bit to a binary phase, counts completed revolutions, and raises pulse and sticky error flags when the ring misbehaves. It sits between the ring counter and any phase-sequenced logic, which uses phase only while locked=1.

Parameters:
N, 4, ring width in bits; must be at least 2.
LOCK_CNT, 2, consecutive correct advances required to enter LOCKED; must be at least 1.
REV_W, 8, width of the revolution counter.
PHASE_W, derived as $clog2(N), width of the phase output; not overridable.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
ring_in  in  N  one-hot ring counter output; the ring rotates left (bit i moves to bit i+1, bit N-1 moves to bit 0).
ring_load  in  1  driven by the same signal that preloads the ring; forces a resynchronise with no error.
clr_err  in  1  clears err_sticky.
phase  out  PHASE_W  binary index of the active ring bit; valid only while locked=1.
locked  out  1  high while in the LOCKED state.
rev_count  out  REV_W  number of completed revolutions observed while locked.
err_onehot  out  1  one-cycle pulse: ring_in was not one-hot while locked.
err_seq  out  1  one-cycle pulse: ring_in was one-hot but not the rotate-left of the last sample, while locked.
err_sticky  out  1  set by either error pulse; held until clr_err or rst.

Behaviour:
- All outputs are registered. The decision on the ring_in value sampled at edge k is visible on the outputs immediately after edge k.
- Internal registers:
  - state: SEARCH, CHECK or LOCKED.
  - last: N bits, the last accepted ring value.
  - good: consecutive correct-advance counter.
  - oh: combinational flag, ring_in has exactly one bit set.
  - nxt: combinational, last rotated left by one position.
- Priority at each edge: rst, then ring_load, then normal operation.
- rst:
  - state=SEARCH; last=0; good=0; phase=0; locked=0; rev_count=0.
  - err_onehot=0; err_seq=0; err_sticky=0.
- ring_load=1:
  - state=SEARCH; good=0; locked=0.
  - Both error pulses are 0.
  - rev_count, err_sticky and phase hold their values.
- SEARCH:
  - If oh: last=ring_in, good=0, go to CHECK.
  - Otherwise stay in SEARCH. No errors are raised.
- CHECK:
  - If ring_in==nxt: last=ring_in, good=good+1. If good+1==LOCK_CNT, go to LOCKED, set locked=1 and phase=index of ring_in.
  - Else if oh: last=ring_in, good=0, stay in CHECK (restart the count).
  - Else go to SEARCH with good=0.
  - No errors are raised in CHECK.
- LOCKED:
  - If ring_in==nxt: last=ring_in and phase=index of ring_in. If ring_in[0]==1 (wrap from phase N-1 to phase 0), rev_count increments, wrapping from 2^REV_W-1 to 0.
  - Else: locked=0, state=SEARCH, good=0, err_sticky=1. Pulse err_onehot if not oh, otherwise pulse err_seq.
  - A ring_in that holds its value (does not advance) counts as err_seq.
- The first entry into LOCKED does not increment rev_count, even when the entry value is ring_in[0]=1.
- Error pulses last exactly one cycle and are never both high in the same cycle.
- clr_err and a new error on the same edge: set wins, so err_sticky=1.
- clr_err alone clears err_sticky; it has no other effect.
- phase holds its last value outside LOCKED.
- Encoder: phase is the index of the single set bit. It is only computed from one-hot values.

Test Plan:
(Parameters N=4, LOCK_CNT=2 throughout.)
- Lock and wrap: rst for 1 cycle, then ring_in = 0001,0010,0100,1000,0001,0010.
  Required: CHECK after the 0001 edge; locked=1 with phase=2 after the 0100 edge; phase=3, then 0 with rev_count=1, then 1; no errors.
- Skip error: while locked at phase 1 (ring_in=0010), drive 1000.
  Required: err_seq=1 for one cycle; err_sticky=1; locked=0.
  Then 0001,0010,0100 relocks, with locked=1 after the 0100 edge; err_sticky stays 1.
- Non-one-hot: while locked, drive 0110.
  Required: err_onehot=1 for one cycle, err_seq=0, err_sticky=1.
  Then 0000 for 3 cycles keeps the block in SEARCH with no further pulses.
- Stall counts as error: while locked, hold 0100 for two cycles.
  Required: err_seq pulse after the second sample.
- ring_load resync: while locked, assert ring_load for 1 cycle with ring_in=0001.
  Required: locked=0, no error pulse, rev_count unchanged; relock after two correct advances.
- Sticky clear and rev wrap:
  - With REV_W=2, run 5 revolutions. Required: rev_count goes 1,2,3,0,1.
  - Assert clr_err alone. Required: err_sticky=0.
  - Assert clr_err on the same edge as an error. Required: err_sticky=1.
